// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game core with body, food, growth, collisions and cell colour query
// Build option: define SNAKE_WRAP_EN to make the grid edges wrap instead of killing the snake.
module snake_engine #(
    parameter int GRID_W   = 20,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int TICK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    input  logic [7:0]  video_x,
    input  logic [7:0]  video_y,
    output logic [23:0] video_rgb,
    output logic [6:0]  length,
    output logic        game_over
);

    localparam int TW = $clog2(TICK_DIV);

    localparam logic [23:0] RGB_HEAD    = 24'ha000a0;
    localparam logic [23:0] RGB_BODY    = 24'h600060;
    localparam logic [23:0] RGB_FOOD    = 24'h00c000;
    localparam logic [23:0] RGB_BG_PLAY = 24'hffffff;
    localparam logic [23:0] RGB_BG_DEAD = 24'hff8080;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    // Snake state: seg 0 is the head
    logic [7:0]    seg_x_q [MAX_LEN];
    logic [7:0]    seg_y_q [MAX_LEN];
    logic [6:0]    len_q;
    dir_t          dir_q;
    state_t        state_q;
    logic          go_q;
    logic [7:0]    food_x_q;
    logic [7:0]    food_y_q;
    logic [TW-1:0] tick_q;
    logic [3:0]    pend_q;

    // Free-running food candidate
    logic [7:0]    fx_q;
    logic [7:0]    fy_q;

    // Registered video answer
    logic [23:0]   rgb_q;
    logic [23:0]   rgb_d;

    // Step decision signals
    logic [3:0]    btn;
    logic [3:0]    eff;
    logic          restart;
    logic          step;
    dir_t          dir_d;
    logic [8:0]    nx9;
    logic [8:0]    ny9;
    logic          wall;
    logic          eat;
    logic          self_hit;
    logic [6:0]    lim;

    // Video match signals
    logic          in_grid;
    logic          hit_head;
    logic          hit_body;
    logic          hit_food;

    assign btn     = {down, up, right, left};
    // Presses in the step cycle itself still count towards the decision
    assign eff     = pend_q | btn;
    assign restart = reset || ((state_q == ST_DEAD) && (|btn));
    assign step    = (state_q == ST_PLAY) && (tick_q == TW'(TICK_DIV - 1));

    // Resolve the pending presses into a direction and compute the next head cell
    always_comb begin
        dir_d = dir_q;
        if (eff[0] && dir_q != DIR_RIGHT) begin
            dir_d = DIR_LEFT;
        end else if (eff[1] && dir_q != DIR_LEFT) begin
            dir_d = DIR_RIGHT;
        end else if (eff[2] && dir_q != DIR_DOWN) begin
            dir_d = DIR_UP;
        end else if (eff[3] && dir_q != DIR_UP) begin
            dir_d = DIR_DOWN;
        end

        nx9 = {1'b0, seg_x_q[0]};
        ny9 = {1'b0, seg_y_q[0]};
        case (dir_d)
            DIR_LEFT:  nx9 = nx9 - 9'd1;
            DIR_RIGHT: nx9 = nx9 + 9'd1;
            DIR_UP:    ny9 = ny9 - 9'd1;
            DIR_DOWN:  ny9 = ny9 + 9'd1;
        endcase

`ifdef SNAKE_WRAP_EN
        if (nx9 == 9'h1ff) begin
            nx9 = 9'(GRID_W - 1);
        end else if (nx9 == 9'(GRID_W)) begin
            nx9 = 9'd0;
        end
        if (ny9 == 9'h1ff) begin
            ny9 = 9'(GRID_H - 1);
        end else if (ny9 == 9'(GRID_H)) begin
            ny9 = 9'd0;
        end
        wall = 1'b0;
`else
        // -1 shows up as 9'h1ff, so a single unsigned compare covers both edges
        wall = (nx9 >= 9'(GRID_W)) || (ny9 >= 9'(GRID_H));
`endif
    end

    // Food and self-collision checks; the tail only stays put when eating
    always_comb begin
        eat      = (nx9[7:0] == food_x_q) && (ny9[7:0] == food_y_q);
        lim      = eat ? len_q : (len_q - 7'd1);
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((7'(i) < lim) && (seg_x_q[i] == nx9[7:0]) && (seg_y_q[i] == ny9[7:0])) begin
                self_hit = 1'b1;
            end
        end
    end

    // Colour of the queried cell with head > body > food > background priority
    always_comb begin
        in_grid  = (video_x < 8'(GRID_W)) && (video_y < 8'(GRID_H));
        hit_head = (seg_x_q[0] == video_x) && (seg_y_q[0] == video_y);
        hit_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((7'(i) < len_q) && (seg_x_q[i] == video_x) && (seg_y_q[i] == video_y)) begin
                hit_body = 1'b1;
            end
        end
        hit_food = (food_x_q == video_x) && (food_y_q == video_y);

        rgb_d = (state_q == ST_DEAD) ? RGB_BG_DEAD : RGB_BG_PLAY;
        if (in_grid) begin
            if (hit_head) begin
                rgb_d = RGB_HEAD;
            end else if (hit_body) begin
                rgb_d = RGB_BODY;
            end else if (hit_food) begin
                rgb_d = RGB_FOOD;
            end
        end
    end

    // Game FSM: restart/reset, direction latching, stepping, growth and death
    always_ff @(posedge clk) begin
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= 8'(GRID_W / 2 + i);
                seg_y_q[i] <= 8'(GRID_H / 2);
            end
            len_q    <= 7'd3;
            dir_q    <= DIR_LEFT;
            food_x_q <= 8'd1;
            food_y_q <= 8'd1;
            tick_q   <= '0;
            pend_q   <= '0;
            state_q  <= ST_PLAY;
            go_q     <= 1'b0;
        end else if (state_q == ST_PLAY) begin
            if (step) begin
                tick_q <= '0;
                pend_q <= '0;
                dir_q  <= dir_d;
                if (wall || self_hit) begin
                    state_q <= ST_DEAD;
                    go_q    <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_q[i] <= seg_x_q[i-1];
                        seg_y_q[i] <= seg_y_q[i-1];
                    end
                    seg_x_q[0] <= nx9[7:0];
                    seg_y_q[0] <= ny9[7:0];
                    if (eat) begin
                        if (len_q < 7'(MAX_LEN)) begin
                            len_q <= len_q + 7'd1;
                        end
                        food_x_q <= fx_q;
                        food_y_q <= fy_q;
                    end
                end
            end else begin
                tick_q <= tick_q + TW'(1);
                pend_q <= eff;
            end
        end
    end

    // Food candidate scans the grid one cell per clock, unaffected by restarts
    always_ff @(posedge clk) begin
        if (reset) begin
            fx_q <= 8'd0;
            fy_q <= 8'd0;
        end else if (fx_q == 8'(GRID_W - 1)) begin
            fx_q <= 8'd0;
            fy_q <= (fy_q == 8'(GRID_H - 1)) ? 8'd0 : (fy_q + 8'd1);
        end else begin
            fx_q <= fx_q + 8'd1;
        end
    end

    // Register the video answer for one clock of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= RGB_BG_PLAY;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign video_rgb = rgb_q;
    assign length    = len_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - scoreboard bench for snake_engine against a queue-based game model
module tb_snake_engine;

    localparam int GW = 20;
    localparam int GH = 30;
    localparam int ML = 6;
    localparam int TD = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        left;
    logic        right;
    logic        up;
    logic        down;
    logic [7:0]  video_x;
    logic [7:0]  video_y;
    logic [23:0] video_rgb;
    logic [6:0]  length;
    logic        game_over;

    always #5 clk = ~clk;

    snake_engine #(
        .GRID_W  (GW),
        .GRID_H  (GH),
        .MAX_LEN (ML),
        .TICK_DIV(TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .left     (left),
        .right    (right),
        .up       (up),
        .down     (down),
        .video_x  (video_x),
        .video_y  (video_y),
        .video_rgb(video_rgb),
        .length   (length),
        .game_over(game_over)
    );

    typedef struct {
        logic [23:0] rgb;
        int          len;
        logic        go;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference game: body as a list of cells, head first
    int       bx[$];
    int       by[$];
    int       food_x, food_y;
    int       fxc, fyc;
    int       dir;          // 0 left, 1 right, 2 up, 3 down
    int       tick;
    logic [3:0] pend;
    bit       dead;

    function automatic int dx_of(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic int dy_of(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int opposite(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
    endfunction

    task automatic model_init(input bit keep_food_ctr);
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(GW / 2 + i);
            by.push_back(GH / 2);
        end
        dir    = 0;
        food_x = 1;
        food_y = 1;
        tick   = 0;
        pend   = 4'b0;
        dead   = 1'b0;
        if (!keep_food_ctr) begin
            fxc = 0;
            fyc = 0;
        end
    endtask

    function automatic logic [23:0] model_rgb(input int qx, input int qy);
        if (qx < GW && qy < GH) begin
            if (bx[0] == qx && by[0] == qy) return 24'ha000a0;
            for (int i = 1; i < bx.size(); i++)
                if (bx[i] == qx && by[i] == qy) return 24'h600060;
            if (food_x == qx && food_y == qy) return 24'h00c000;
        end
        return dead ? 24'hff8080 : 24'hffffff;
    endfunction

    task automatic model_step(input logic [3:0] eff);
        int  nx, ny, lim;
        bit  wall, eat, hit;
        for (int p = 0; p < 4; p++) begin
            if (eff[p] && p != opposite(dir)) begin
                dir = p;
                break;
            end
        end
        nx = bx[0] + dx_of(dir);
        ny = by[0] + dy_of(dir);
`ifdef SNAKE_WRAP_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
`endif
        wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
        eat  = !wall && nx == food_x && ny == food_y;
        lim  = eat ? bx.size() : bx.size() - 1;
        hit  = 1'b0;
        for (int i = 0; i < lim; i++)
            if (bx[i] == nx && by[i] == ny) hit = 1'b1;
        if (wall || hit) begin
            dead = 1'b1;
        end else begin
            bx.push_front(nx);
            by.push_front(ny);
            if (eat) begin
                food_x = fxc;
                food_y = fyc;
            end
            if (!eat || bx.size() > ML) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
        end
    endtask

    task automatic model_clock(input logic rst, input logic [3:0] b);
        if (rst) begin
            model_init(1'b0);
            return;
        end
        if (dead) begin
            if (|b) model_init(1'b1);
        end else if (tick == TD - 1) begin
            model_step(pend | b);
            pend = 4'b0;
            tick = 0;
        end else begin
            pend = pend | b;
            tick = tick + 1;
        end
        fxc = fxc + 1;
        if (fxc == GW) begin
            fxc = 0;
            fyc = (fyc == GH - 1) ? 0 : fyc + 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one clock of stimulus and queue the response expected after that edge
    task automatic cycle(input logic rst, input logic [3:0] b, input logic [7:0] qx, input logic [7:0] qy);
        exp_t e;
        reset   = rst;
        left    = b[0];
        right   = b[1];
        up      = b[2];
        down    = b[3];
        video_x = qx;
        video_y = qy;
        e.rgb   = rst ? 24'hffffff : model_rgb(int'(qx), int'(qy));
        model_clock(rst, b);
        e.len   = bx.size();
        e.go    = dead;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compare whatever the DUT shows against the oldest queued expectation
    exp_t m;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check("video_rgb", {8'h0, video_rgb}, {8'h0, m.rgb});
            check("length", {25'h0, length}, m.len);
            check("game_over", {31'h0, game_over}, {31'h0, m.go});
        end
    end

    function automatic logic [3:0] chase_btn();
        if (food_x < bx[0]) return 4'b0001;
        if (food_x > bx[0]) return 4'b0010;
        if (food_y < by[0]) return 4'b0100;
        return 4'b1000;
    endfunction

    initial begin
        logic [3:0] b;
        logic [7:0] qx, qy;
        logic       r;
        int         k, idx;

        reset = 1'b1; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
        video_x = 8'd0; video_y = 8'd0;
        model_init(1'b0);

        cycle(1'b1, 4'b0, 8'(GW / 2), 8'(GH / 2));
        cycle(1'b1, 4'b0, 8'(GW / 2), 8'(GH / 2));

        // Idle: first step moves the head one cell left
        for (int i = 0; i < TD + 2; i++) cycle(1'b0, 4'b0, 8'(GW / 2 - 1), 8'(GH / 2));
        // Reversal request alone is ignored; with up it falls through to up
        for (int i = 0; i < TD; i++) cycle(1'b0, 4'b0010, 8'(bx[0]), 8'(by[0]));
        for (int i = 0; i < TD; i++) cycle(1'b0, 4'b0110, 8'(bx[0]), 8'(by[0]));
        for (int i = 0; i < TD; i++) cycle(1'b0, 4'b0, 8'(bx[0]), 8'(by[0] + 1));

        for (int n = 0; n < 25000; n++) begin
            r = ($urandom_range(0, 999) == 0);
            if (dead) begin
                b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            end else begin
                k = $urandom_range(0, 99);
                if (k < 50) b = chase_btn();
                else if (k < 65) b = 4'($urandom_range(0, 15));
                else b = 4'b0;
            end
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: begin
                    idx = $urandom_range(0, bx.size() - 1);
                    qx  = 8'(bx[idx]);
                    qy  = 8'(by[idx]);
                end
                3: begin
                    qx = 8'(food_x);
                    qy = 8'(food_y);
                end
                4: begin
                    qx = 8'(bx[0] + $urandom_range(0, 2) - 1);
                    qy = 8'(by[0] + $urandom_range(0, 2) - 1);
                end
                5: begin
                    qx = 8'(GW);
                    qy = 8'($urandom_range(0, GH - 1));
                end
                6: begin
                    qx = 8'($urandom_range(0, GW - 1));
                    qy = 8'(GH);
                end
                7: begin
                    qx = 8'($urandom_range(0, 255));
                    qy = 8'($urandom_range(0, 255));
                end
                default: begin
                    qx = 8'($urandom_range(0, GW - 1));
                    qy = 8'($urandom_range(0, GH - 1));
                end
            endcase
            cycle(r, b, qx, qy);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
